// File: rtl/async_read_cache.sv
// rtl/async_read_cache.sv - direct-mapped read-only byte cache with 4-word burst line fill
module async_read_cache #(
    parameter int LINES      = 16,
    parameter int ADDR_WIDTH = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_in_rd,
    input  logic [ADDR_WIDTH-1:0] io_in_addr,
    output logic                  io_in_wait_n,
    output logic                  io_in_valid,
    output logic [7:0]            io_in_dout,
    output logic                  io_out_rd,
    output logic [ADDR_WIDTH-1:0] io_out_addr,
    input  logic                  io_out_wait_n,
    input  logic                  io_out_valid,
    input  logic [63:0]           io_out_dout
);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = ADDR_WIDTH - 5 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, CHECK, REQ, FILL} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              cnt_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [63:0]             data_q [LINES][4];
    logic [7:0]              dout_q;
    logic                    pulse_q;

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]     tag;
    logic [1:0]              word;
    logic [2:0]              lane;
    logic [63:0]             sel_word;
    logic                    hit;
    logic                    accept;
    logic                    fill_beat;
    logic                    last_beat;

    // Every lookup and fill works on the latched request address.
    assign idx       = addr_q[5+INDEX_BITS-1:5];
    assign tag       = addr_q[ADDR_WIDTH-1:5+INDEX_BITS];
    assign word      = addr_q[4:3];
    assign lane      = addr_q[2:0];
    assign sel_word  = data_q[idx][word];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);

    assign accept    = io_in_rd && (state_q == IDLE);
    assign fill_beat = (state_q == FILL) && io_out_valid;
    assign last_beat = fill_beat && (cnt_q == 2'd3);

    assign io_in_wait_n = (state_q == IDLE);
    assign io_in_valid  = pulse_q;
    assign io_in_dout   = dout_q;
    assign io_out_rd    = (state_q == REQ);
    assign io_out_addr  = {addr_q[ADDR_WIDTH-1:5], 5'b0};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a completed fill re-enters CHECK, where it is a guaranteed hit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept)        state_d = CHECK;
            CHECK: state_d = hit ? IDLE : REQ;
            REQ:   if (io_out_wait_n) state_d = FILL;
            FILL:  if (last_beat)     state_d = CHECK;
            default: state_d = IDLE;
        endcase
    end

    // Latch the byte address of each accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= io_in_addr;
        end
    end

    // Burst word counter; wraps back to zero on the fourth word.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 2'd0;
        end else if (fill_beat) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    // Line valid bits: dropped on the first fill word so a half-filled line can never hit.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_beat && (cnt_q == 2'd0)) begin
            valid_q[idx] <= 1'b0;
        end else if (last_beat) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage; burst words go straight into the line without staging.
    always_ff @(posedge clock) begin
        if (fill_beat) begin
            data_q[idx][cnt_q] <= io_out_dout;
        end
        if (last_beat) begin
            tag_q[idx] <= tag;
        end
    end

    // Hit response: register the selected byte and pulse valid for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q  <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= (state_q == CHECK) && hit;
            if ((state_q == CHECK) && hit) begin
                dout_q <= sel_word[{lane, 3'b000} +: 8];
            end
        end
    end
endmodule

// File: tb/tb_async_read_cache.sv
// tb/tb_async_read_cache.sv - scoreboard bench for async_read_cache
module tb_async_read_cache;
    logic        clock;
    logic        reset;
    logic        io_in_rd;
    logic [24:0] io_in_addr;
    logic        io_in_wait_n;
    logic        io_in_valid;
    logic [7:0]  io_in_dout;
    logic        io_out_rd;
    logic [24:0] io_out_addr;
    logic        io_out_wait_n;
    logic        io_out_valid;
    logic [63:0] io_out_dout;

    async_read_cache #(.LINES(16), .ADDR_WIDTH(25)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_rd     (io_in_rd),
        .io_in_addr   (io_in_addr),
        .io_in_wait_n (io_in_wait_n),
        .io_in_valid  (io_in_valid),
        .io_in_dout   (io_in_dout),
        .io_out_rd    (io_out_rd),
        .io_out_addr  (io_out_addr),
        .io_out_wait_n(io_out_wait_n),
        .io_out_valid (io_out_valid),
        .io_out_dout  (io_out_dout)
    );

    typedef struct {
        logic [7:0] data;
        int         acc;
        bit         hit;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          bursts = 0;
    int          last_words = 0;
    int          stall_req  = 0;
    int          fill_limit = 4;
    bit          abort_done = 0;
    logic [24:0] exp_line = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Memory byte at address a is a[7:0] with a[11:9] folded into the top bits.
    function automatic logic [63:0] mk(input logic [24:0] line, input int w);
        logic [24:0] a;
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            a = line + 25'(8 * w + k);
            r[8*k +: 8] = a[7:0] ^ {a[11:9], 5'b0};
        end
        return r;
    endfunction

    // Memory controller model.
    initial begin
        logic [24:0] line;
        io_out_wait_n = 1'b1;
        io_out_valid  = 1'b0;
        io_out_dout   = '0;
        forever begin
            @(negedge clock);
            if (io_out_rd && !reset) begin
                line = io_out_addr;
                bursts++;
                last_words = 0;
                check("out_addr", line, exp_line);
                for (int s = 0; s < stall_req; s++) begin
                    io_out_wait_n = 1'b0;
                    @(negedge clock);
                    check("stall_rd", io_out_rd, 1);
                    check("stall_addr", io_out_addr, line);
                    check("stall_wait_n", io_in_wait_n, 0);
                end
                stall_req = 0;
                io_out_wait_n = 1'b1;
                @(negedge clock);
                check("rd_drop", io_out_rd, 0);
                for (int w = 0; w < fill_limit; w++) begin
                    io_out_valid = 1'b1;
                    io_out_dout  = mk(line, w);
                    @(negedge clock);
                    io_out_valid = 1'b0;
                    last_words++;
                end
                if (fill_limit < 4) abort_done = 1;
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (io_in_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", io_in_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", io_in_dout, e.data);
                    if (e.hit) check("hit_latency", 64'(cyc - e.acc), 2);
                end
            end
        end
    end

    task automatic issue(input logic [24:0] addr, input logic [7:0] data, input bit hit, input bit push);
        exp_t e;
        int t;
        t = 0;
        while (!io_in_wait_n && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("accept_timeout", t < 200, 1);
        io_in_rd   = 1'b1;
        io_in_addr = addr;
        e.data = data;
        e.acc  = cyc;
        e.hit  = hit;
        if (push) exp_q.push_back(e);
        @(negedge clock);
        io_in_rd = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !io_in_wait_n) && t < 500) begin
            @(negedge clock);
            t++;
        end
        check("idle_timeout", t < 500, 1);
    endtask

    initial begin
        reset      = 1'b1;
        io_in_rd   = 1'b0;
        io_in_addr = '0;
        repeat (3) @(negedge clock);
        check("rst_wait_n", io_in_wait_n, 1);
        check("rst_valid", io_in_valid, 0);
        check("rst_dout", io_in_dout, 0);
        check("rst_out_rd", io_out_rd, 0);
        check("rst_out_addr", io_out_addr, 0);
        reset = 1'b0;
        @(negedge clock);

        exp_line = 25'h120;
        issue(25'h123, 8'h23, 0, 1);
        wait_idle();
        check("cold_bursts", bursts, 1);
        check("cold_words", last_words, 4);

        issue(25'h13F, 8'h3F, 1, 1);
        wait_idle();
        check("hit_bursts", bursts, 1);

        for (int i = 0; i < 8; i++) issue(25'h120 + 25'(i), 8'h20 + 8'(i), 1, 1);
        wait_idle();
        check("b2b_bursts", bursts, 1);

        exp_line  = 25'h1000;
        stall_req = 5;
        issue(25'h1005, 8'h05, 0, 1);
        wait_idle();
        check("stall_bursts", bursts, 2);

        exp_line = 25'h320;
        issue(25'h320, 8'h00, 0, 1);
        wait_idle();
        check("conflict_bursts", bursts, 3);
        exp_line = 25'h120;
        issue(25'h120, 8'h20, 0, 1);
        wait_idle();
        check("refill_bursts", bursts, 4);

        exp_line   = 25'h440;
        fill_limit = 2;
        issue(25'h445, 8'h00, 0, 0);
        begin
            int t;
            t = 0;
            while (!abort_done && t < 200) begin
                @(negedge clock);
                t++;
            end
            check("abort_timeout", t < 200, 1);
        end
        check("abort_words", last_words, 2);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("abort_wait_n", io_in_wait_n, 1);
        check("abort_valid", io_in_valid, 0);
        reset      = 1'b0;
        fill_limit = 4;
        abort_done = 0;
        repeat (3) @(negedge clock);
        issue(25'h445, 8'h05, 0, 1);
        wait_idle();
        check("reread_bursts", bursts, 6);
        check("reread_words", last_words, 4);

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
